// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, ACK/NACK levels, default target
// address and the decoded line-event bundle.
`timescale 1ns/1ps
package i2c_pkg;

  localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h39;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_REG       = 4'd3;
  localparam logic [3:0] ST_REG_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_WAIT      = 4'd9;

  // One-cycle events decoded from the synchronised bus lines
  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;
  } line_evt_t;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Raw I2C bus lines as seen by a target: clock and data inputs, open-drain
// pull-down enable back to the bus.
`timescale 1ns/1ps
interface i2c_reg_target_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers on SCL/SDA plus SCL edge and START/STOP detection,
// all derived from the synchronised copies.
`timescale 1ns/1ps
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic                    clk_ref,
  input  logic                    reset,
  i2c_reg_target_if.slave         bus,
  output line_evt_t               evt_o
);

  logic [1:0] scl_ff_q;
  logic [1:0] sda_ff_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk_ref) begin
    if (reset) begin
      scl_ff_q   <= 2'b11;
      sda_ff_q   <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_ff_q   <= {scl_ff_q[0], bus.scl};
      sda_ff_q   <= {sda_ff_q[0], bus.sda_in};
      scl_prev_q <= scl_ff_q[1];
      sda_prev_q <= sda_ff_q[1];
    end
  end

  assign scl_s = scl_ff_q[1];
  assign sda_s = sda_ff_q[1];

  // START/STOP require SCL high across both samples so SCL edges never alias
  assign evt_o.scl_rise = scl_s & ~scl_prev_q;
  assign evt_o.scl_fall = ~scl_s & scl_prev_q;
  assign evt_o.start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign evt_o.stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign evt_o.sda      = sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C register target: address match, register-pointer write, auto-incrementing
// byte writes to the host and byte reads from the host at the current pointer.
`timescale 1ns/1ps
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR_DEFAULT
) (
  input  logic       clk_ref,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic [7:0] rd_reg,
  input  logic [7:0] rd_data,
  output logic       rd_strobe,
  output logic       busy,
  output logic [3:0] state_out
);

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_reg_q, wr_reg_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_in;
  logic       load_rd;
  line_evt_t  evt;

  i2c_reg_target_if u_bus ();
  assign u_bus.scl    = scl;
  assign u_bus.sda_in = sda_in;
  assign u_bus.sda_oe = sda_oe_q;

  i2c_line_sync u_sync (
    .clk_ref (clk_ref),
    .reset   (reset),
    .bus     (u_bus),
    .evt_o   (evt)
  );

  assign byte_in = {shift_q, evt.sda};

  // NOTE: every variable gets its default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    wr_valid_d  = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;
    load_rd     = 1'b0;

    if (evt.stop) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (evt.start) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      if (state_q == ST_WAIT) busy_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (evt.scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == ST_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_WAIT;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_REG) begin
                ptr_d   = byte_in;
                state_d = ST_REG_ACK;
              end else begin
                wr_valid_d = 1'b1;
                wr_reg_d   = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + 8'd1;
                state_d    = ST_WDATA_ACK;
              end
            end
          end
        end

        // First fall after the byte drives ACK; the next fall ends the ACK slot
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (evt.scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = ~ACK_BIT;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == ST_ADDR_ACK && rw_q) load_rd = 1'b1;
              else if (state_q == ST_ADDR_ACK)    state_d = ST_REG;
              else                                state_d = ST_WDATA;
            end
          end
        end

        ST_RDATA: begin
          if (evt.scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (evt.scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_RDATA_ACK;
            end else if (cnt_q != 4'd0) begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end

        // Pointer advances past every byte sent; only an ACK asks for another
        ST_RDATA_ACK: begin
          if (evt.scl_rise) begin
            ptr_d = ptr_q + 8'd1;
            if (evt.sda == ACK_BIT) cnt_d = 4'd1;
            else                    state_d = ST_WAIT;
          end else if (evt.scl_fall && cnt_q == 4'd1) begin
            load_rd = 1'b1;
          end
        end

        default: ;
      endcase
    end

    if (load_rd) begin
      tx_d        = rd_data[6:0];
      sda_oe_d    = ~rd_data[7];
      rd_strobe_d = 1'b1;
      cnt_d       = '0;
      state_d     = ST_RDATA;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = u_bus.sda_oe;
  assign wr_valid  = wr_valid_q;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign rd_reg    = ptr_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: a bit-banged bus master, a host register array and
// a transaction-level model of pointer/write/read behaviour.
`timescale 1ns/1ps
module tb_i2c_reg_target;
  import i2c_pkg::*;

  localparam int         Q     = 100;     // quarter SCL period, 10 clk_ref cycles
  localparam logic [6:0] ADDR7 = 7'h39;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       wr_valid, rd_strobe, busy;
  logic [7:0] wr_reg, wr_data, rd_reg, rd_data;
  logic [3:0] state_out;
  logic [7:0] host_mem [256];

  i2c_reg_target_if bus ();
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;
  assign rd_data    = host_mem[rd_reg];

  always #5 clk = ~clk;

  i2c_reg_target #(.DEV_ADDR(ADDR7)) dut (
    .clk_ref   (clk),
    .reset     (reset),
    .scl       (bus.scl),
    .sda_in    (bus.sda_in),
    .sda_oe    (bus.sda_oe),
    .wr_valid  (wr_valid),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_reg    (rd_reg),
    .rd_data   (rd_data),
    .rd_strobe (rd_strobe),
    .busy      (busy),
    .state_out (state_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: only this process writes these logs and counters
  logic [7:0] wr_log_reg[$];
  logic [7:0] wr_log_dat[$];
  int rd_strobes = 0, oe_cycles = 0, busy_cycles = 0;

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_log_reg.push_back(wr_reg);
      wr_log_dat.push_back(wr_data);
    end
    if (rd_strobe)  rd_strobes++;
    if (bus.sda_oe) oe_cycles++;
    if (busy)       busy_cycles++;
  end

  // Reference model: pointer retained across transactions
  logic [7:0] m_ptr = 8'h00;
  logic [7:0] tx_bytes[$];

  task automatic clock_bit(input logic b, output logic s);
    #Q sda_m = b;
    #Q scl_m = 1'b1;
    #Q s = bus.sda_in;
    #Q scl_m = 1'b0;
  endtask

  task automatic start_cond();
    #Q sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(mack, s);
  endtask

  // Write transaction from tx_bytes; the model decides ACKs and expected writes
  task automatic write_txn(input logic [7:0] addr_byte, input string tag, input bit do_stop);
    int         wr0, oe0, busy0;
    logic       ack;
    bit         match;
    logic [7:0] exp_reg[$];
    logic [7:0] exp_dat[$];
    wr0   = wr_log_reg.size();
    oe0   = oe_cycles;
    busy0 = busy_cycles;
    match = (addr_byte[7:1] == ADDR7) && !addr_byte[0];
    start_cond();
    send_byte(addr_byte, ack);
    check({tag, "/addr_ack"}, ack, match ? ACK_BIT : NACK_BIT);
    for (int i = 0; i < tx_bytes.size(); i++) begin
      send_byte(tx_bytes[i], ack);
      check({tag, "/data_ack"}, ack, match ? ACK_BIT : NACK_BIT);
      if (match) begin
        if (i == 0) m_ptr = tx_bytes[0];
        else begin
          exp_reg.push_back(m_ptr);
          exp_dat.push_back(tx_bytes[i]);
          m_ptr = m_ptr + 8'd1;
        end
      end
    end
    if (do_stop) stop_cond();
    repeat (6) @(negedge clk);
    check({tag, "/wr_count"}, wr_log_reg.size() - wr0, exp_reg.size());
    for (int i = 0; i < exp_reg.size() && wr0 + i < wr_log_reg.size(); i++) begin
      check({tag, "/wr_reg"}, wr_log_reg[wr0 + i], exp_reg[i]);
      check({tag, "/wr_data"}, wr_log_dat[wr0 + i], exp_dat[i]);
    end
    check({tag, "/rd_reg"}, rd_reg, m_ptr);
    check({tag, "/oe_seen"}, oe_cycles != oe0, match);
    check({tag, "/busy_seen"}, busy_cycles != busy0, match);
    if (do_stop) begin
      check({tag, "/busy_end"}, busy, 1'b0);
      check({tag, "/state_end"}, state_out, ST_IDLE);
    end
  endtask

  // Read n bytes from the current pointer, master ACKs all but the last
  task automatic read_txn(input int n, input string tag);
    int         rs0;
    logic       ack;
    logic [7:0] b;
    rs0 = rd_strobes;
    start_cond();
    send_byte({ADDR7, 1'b1}, ack);
    check({tag, "/addr_ack"}, ack, ACK_BIT);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? NACK_BIT : ACK_BIT, b);
      check({tag, "/rd_byte"}, b, host_mem[m_ptr]);
      m_ptr = m_ptr + 8'd1;
    end
    stop_cond();
    repeat (6) @(negedge clk);
    check({tag, "/rd_strobes"}, rd_strobes - rs0, n);
    check({tag, "/rd_reg"}, rd_reg, m_ptr);
    check({tag, "/state_end"}, state_out, ST_IDLE);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic       s;
    logic [7:0] a;
    int         wr0, kind, len;
    logic [6:0] bad7;

    for (int i = 0; i < 256; i++) host_mem[i] = 8'($urandom);

    repeat (4) @(posedge clk);
    #1;
    check("reset/sda_oe", bus.sda_oe, 1'b0);
    check("reset/wr_valid", wr_valid, 1'b0);
    check("reset/rd_strobe", rd_strobe, 1'b0);
    check("reset/busy", busy, 1'b0);
    check("reset/state", state_out, ST_IDLE);
    check("reset/wr_reg", wr_reg, 8'h00);
    check("reset/wr_data", wr_data, 8'h00);
    check("reset/rd_reg", rd_reg, 8'h00);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);

    tx_bytes = {8'h98, 8'h03};
    write_txn(8'h72, "single_write", 1'b1);

    tx_bytes = {8'hFE, 8'h11, 8'h22, 8'h33};
    write_txn(8'h72, "wrap_write", 1'b1);

    tx_bytes = {8'h55, 8'hAA};
    write_txn(8'h74, "wrong_addr", 1'b1);

    host_mem[8'h41] = 8'h10;
    host_mem[8'h42] = 8'h5A;
    tx_bytes = {8'h41};
    write_txn(8'h72, "ptr_set", 1'b0);
    read_txn(2, "rep_start_read");

    // STOP in the middle of a data byte
    wr0 = wr_log_reg.size();
    tx_bytes = {8'h10};
    start_cond();
    send_byte(8'h72, s);
    check("partial/addr_ack", s, ACK_BIT);
    send_byte(8'h10, s);
    check("partial/ptr_ack", s, ACK_BIT);
    m_ptr = 8'h10;
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    stop_cond();
    repeat (6) @(negedge clk);
    check("partial/wr_count", wr_log_reg.size() - wr0, 0);
    check("partial/state", state_out, ST_IDLE);
    check("partial/sda_oe", bus.sda_oe, 1'b0);
    check("partial/rd_reg", rd_reg, m_ptr);

    // Reset while the address ACK is being driven
    wr0 = wr_log_reg.size();
    a = 8'h72;
    start_cond();
    for (int i = 7; i >= 0; i--) clock_bit(a[i], s);
    #(Q / 2);
    check("rst_ack/ack_driven", bus.sda_oe, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ack/sda_oe", bus.sda_oe, 1'b0);
    check("rst_ack/state", state_out, ST_IDLE);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    m_ptr = 8'h00;
    repeat (20) @(negedge clk);
    check("rst_ack/no_pulse", wr_log_reg.size() - wr0, 0);
    check("rst_ack/rd_reg", rd_reg, 8'h00);
    tx_bytes = {8'h20, 8'hAB, 8'hCD};
    write_txn(8'h72, "post_reset_write", 1'b1);

    // Randomised transactions against the model
    for (int k = 0; k < 8; k++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        len = $urandom_range(1, 4);
        tx_bytes.delete();
        for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom));
        write_txn({ADDR7, 1'b0}, "rand_write", 1'b1);
      end else if (kind == 1) begin
        bad7 = 7'($urandom);
        if (bad7 == ADDR7) bad7 = bad7 + 7'd1;
        len = $urandom_range(1, 3);
        tx_bytes.delete();
        for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom));
        write_txn({bad7, 1'($urandom)}, "rand_wrong_addr", 1'b1);
      end else begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < 4; i++) host_mem[8'(m_ptr + 8'(i))] = 8'($urandom);
        read_txn(len, "rand_read");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
